// File: rtl/ether_tx.sv
// ether_tx: RMII transmit framer (preamble/SFD, pad, CRC-32 FCS, IPG).
// Ports: clk/rst (sync, active-high); axiiv/axiid/axiil/axiir payload
// dibit stream in; txen/txd RMII pins out (registered); busy = not idle;
// underrun = one-cycle pulse when a frame is aborted on starvation.
module ether_tx #(
  parameter int MIN_DIBITS = 240,
  parameter int IPG_DIBITS = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  input  logic       axiil,
  output logic       axiir,
  output logic       txen,
  output logic [1:0] txd,
  output logic       busy,
  output logic       underrun
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, DATA, PAD, FCS, IPG
  } state_t;

  localparam logic [12:0] MIN13    = 13'(MIN_DIBITS);
  localparam logic [11:0] IPG_LAST = 12'(IPG_DIBITS - 1);

  state_t      state, state_n;
  logic [11:0] cnt, cnt_n;
  logic [3:0]  k, k_n;
  logic [31:0] crc, crc_n;
  logic        txen_n;
  logic [1:0]  txd_n;
  logic        underrun_n;

  logic [11:0] cnt_sat;
  logic [12:0] cnt_p1;
  logic [31:0] crc_sh;

  // Reflected CRC-32, two serial steps per dibit, bit 0 first.
  function automatic logic [31:0] crc_dibit(
    input logic [31:0] c,
    input logic [1:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 2; b++)
      r = (r >> 1) ^ ((r[0] ^ d[b]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  assign cnt_sat = (cnt == 12'hFFF) ? cnt : cnt + 12'd1;
  assign cnt_p1  = {1'b0, cnt} + 13'd1;
  assign crc_sh  = crc >> {k, 1'b0};
  assign busy    = (state != IDLE);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    k_n        = k;
    crc_n      = crc;
    txen_n     = 1'b0;
    txd_n      = 2'b00;
    underrun_n = 1'b0;
    axiir      = 1'b0;
    unique case (state)
      IDLE: begin
        if (axiiv) begin
          state_n = PREAMBLE;
          cnt_n   = 12'd0;
          crc_n   = 32'hFFFFFFFF;
        end
      end
      PREAMBLE: begin
        txen_n = 1'b1;
        txd_n  = (cnt == 12'd31) ? 2'b11 : 2'b01;
        cnt_n  = cnt + 12'd1;
        if (cnt == 12'd31) begin
          state_n = DATA;
          cnt_n   = 12'd0;
        end
      end
      DATA: begin
        axiir = 1'b1;
        if (axiiv) begin
          txen_n = 1'b1;
          txd_n  = axiid;
          crc_n  = crc_dibit(crc, axiid);
          cnt_n  = cnt_sat;
          if (axiil) begin
            if (cnt_p1 < MIN13) begin
              state_n = PAD;
            end else begin
              state_n = FCS;
              k_n     = 4'd0;
            end
          end
        end else begin
          // starvation mid-frame: abort without FCS
          underrun_n = 1'b1;
          state_n    = IPG;
          cnt_n      = 12'd0;
        end
      end
      PAD: begin
        txen_n = 1'b1;
        crc_n  = crc_dibit(crc, 2'b00);
        cnt_n  = cnt_sat;
        if (cnt_p1 == MIN13) begin
          state_n = FCS;
          k_n     = 4'd0;
        end
      end
      FCS: begin
        txen_n = 1'b1;
        txd_n  = ~crc_sh[1:0];
        k_n    = k + 4'd1;
        if (k == 4'd15) begin
          state_n = IPG;
          cnt_n   = 12'd0;
        end
      end
      IPG: begin
        cnt_n = cnt + 12'd1;
        if (cnt == IPG_LAST) begin
          state_n = IDLE;
          cnt_n   = 12'd0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 12'd0;
      k        <= 4'd0;
      crc      <= 32'hFFFFFFFF;
      txen     <= 1'b0;
      txd      <= 2'b00;
      underrun <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      k        <= k_n;
      crc      <= crc_n;
      txen     <= txen_n;
      txd      <= txd_n;
      underrun <= underrun_n;
    end
  end

endmodule

// File: tb/tb_ether_tx.sv
// tb_ether_tx: directed bench for ether_tx.
// dut0 runs without padding, dut1 with 240-dibit minimum.
module tb_ether_tx;

  typedef logic [7:0] bytes_t[$];
  typedef logic [1:0] dib_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       axiiv = 1'b0;
  logic [1:0] axiid = 2'b00;
  logic       axiil = 1'b0;

  logic       r0, e0, b0, u0;
  logic       r1, e1, b1, u1;
  logic [1:0] t0, t1;
  logic       axiir, txen, busy, underrun;
  logic [1:0] txd;

  int ncomp = 0;
  int nfail = 0;

  always #10 clk = ~clk;

  ether_tx #(.MIN_DIBITS(0), .IPG_DIBITS(48)) dut0 (
    .clk(clk), .rst(rst),
    .axiiv(axiiv & ~sel), .axiid(axiid), .axiil(axiil),
    .axiir(r0), .txen(e0), .txd(t0),
    .busy(b0), .underrun(u0)
  );

  ether_tx #(.MIN_DIBITS(240), .IPG_DIBITS(48)) dut1 (
    .clk(clk), .rst(rst),
    .axiiv(axiiv & sel), .axiid(axiid), .axiil(axiil),
    .axiir(r1), .txen(e1), .txd(t1),
    .busy(b1), .underrun(u1)
  );

  assign axiir    = sel ? r1 : r0;
  assign txen     = sel ? e1 : e0;
  assign txd      = sel ? t1 : t0;
  assign busy     = sel ? b1 : b0;
  assign underrun = sel ? u1 : u0;

  dib_t cap;
  int   hi_n, rise_c, fall_c, ur_n, ur_c;
  int   idle_c, first_rdy, rdy_late;
  int   g = 0;
  int   rise_g, fall_g;
  logic rst_e, rst_b;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ncomp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic dib_t to_dib(input bytes_t b);
    dib_t q;
    q = {};
    foreach (b[j])
      for (int k = 0; k < 4; k++) q.push_back(b[j][2*k +: 2]);
    return q;
  endfunction

  // byte-wise reference CRC-32 (init ones, final complement)
  function automatic logic [31:0] crc_ref(input bytes_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[j]) begin
      c = c ^ {24'h0, b[j]};
      for (int i = 0; i < 8; i++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic dib_t exp_frame(input bytes_t pl, input int mn,
                                     input logic [31:0] fcs);
    dib_t q;
    int   pad;
    q = {};
    for (int i = 0; i < 31; i++) q.push_back(2'b01);
    q.push_back(2'b11);
    q = {q, to_dib(pl)};
    pad = mn - 4 * pl.size();
    for (int i = 0; i < pad; i++) q.push_back(2'b00);
    for (int k = 0; k < 16; k++) q.push_back(fcs[2*k +: 2]);
    return q;
  endfunction

  task automatic chk_cap(input string tag, input dib_t ex);
    chk({tag, ".len"}, cap.size(), ex.size());
    for (int j = 0; j < ex.size() && j < cap.size(); j++)
      chk($sformatf("%s.d%0d", tag, j), {30'h0, cap[j]}, {30'h0, ex[j]});
  endtask

  // Streams one frame; samples outputs on negedges, drives inputs there.
  task automatic run_frame(input logic s, input bytes_t pl,
                           input int drop, input bit hold,
                           input int rst_at);
    dib_t dq;
    int   n, i;
    bit   fire, v;
    dq = to_dib(pl);
    n = dq.size();
    i = 0;
    fire = 1'b0;
    cap = {};
    hi_n = 0; rise_c = -1; fall_c = -1;
    ur_n = 0; ur_c = -1; idle_c = -1;
    first_rdy = -1; rdy_late = 0;
    sel = s;
    for (int c = 0; c < 2000; c++) begin
      if (c > 0) begin
        g++;
        if (fire) i++;
        if (rst) begin
          rst_e = txen;
          rst_b = busy;
          rst = 1'b0;
          idle_c = c;
          break;
        end
        if (txen) begin
          cap.push_back(txd);
          hi_n++;
          if (rise_c < 0) begin rise_c = c; rise_g = g; end
        end else if (rise_c >= 0 && fall_c < 0) begin
          fall_c = c;
          fall_g = g;
        end
        if (underrun) begin ur_n++; ur_c = c; end
        if (!busy) begin idle_c = c; break; end
      end
      if (axiir && first_rdy < 0) first_rdy = c;
      if (axiir && i >= n) rdy_late++;
      v = (i < n) && (drop < 0 || i < drop);
      axiiv = v || (hold && i >= n);
      axiid = v ? dq[i] : 2'b00;
      axiil = v && (i == n - 1);
      fire = axiir && axiiv;
      if (c == rst_at) rst = 1'b1;
      @(negedge clk);
    end
    if (!hold) axiiv = 1'b0;
    axiil = 1'b0;
    axiid = 2'b00;
    chk("frame_done", idle_c >= 0, 1);
  endtask

  initial begin
    bytes_t ab, s9, p14, p20, p2, pad14;
    int     f1;

    ab = '{8'hAB, 8'hCD};
    s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
           8'h36, 8'h37, 8'h38, 8'h39};
    p14 = {};
    for (int i = 0; i < 14; i++) p14.push_back(8'(i * 17 + 3));
    p20 = {};
    for (int i = 0; i < 20; i++) p20.push_back(8'(i * 29 + 5));
    p2 = '{8'h5A, 8'hC3};
    pad14 = p14;
    while (pad14.size() < 60) pad14.push_back(8'h00);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.txen0", e0, 0);
    chk("rst.txd0", t0, 0);
    chk("rst.busy0", b0, 0);
    chk("rst.ur0", u0, 0);
    chk("rst.rdy0", r0, 0);
    chk("rst.txen1", e1, 0);
    chk("rst.busy1", b1, 0);
    chk("rst.ur1", u1, 0);
    rst = 1'b0;
    @(negedge clk);

    // preamble/SFD and first payload, no padding
    run_frame(1'b0, ab, -1, 1'b0, -1);
    chk("ab.rise", rise_c, 2);
    chk("ab.rdy", first_rdy, 33);
    chk("ab.hi", hi_n, 56);
    chk("ab.fall", fall_c, 58);
    chk("ab.idle", idle_c, 105);
    chk("ab.ur", ur_n, 0);
    chk_cap("ab", exp_frame(ab, 0, crc_ref(ab)));

    // CRC check value on "123456789"
    run_frame(1'b0, s9, -1, 1'b0, -1);
    chk("s9.hi", hi_n, 32 + 36 + 16);
    chk("s9.gap", idle_c - fall_c, 47);
    chk("s9.ur", ur_n, 0);
    chk_cap("s9", exp_frame(s9, 0, 32'hCBF43926));

    // short frame padded to 240 dibits
    run_frame(1'b1, p14, -1, 1'b0, -1);
    chk("pad.hi", hi_n, 288);
    chk("pad.rdy", first_rdy, 33);
    chk("pad.fall", fall_c, 290);
    chk("pad.idle", idle_c, 337);
    chk_cap("pad", exp_frame(p14, 240, crc_ref(pad14)));

    // starvation after 10 dibits
    run_frame(1'b0, p20, 10, 1'b0, -1);
    chk("ur.n", ur_n, 1);
    chk("ur.cyc", ur_c, 44);
    chk("ur.fall", fall_c, 44);
    chk("ur.hi", hi_n, 42);
    chk("ur.idle", idle_c, 92);
    begin
      dib_t ex;
      ex = exp_frame(p20, 0, 32'h0);
      ex = ex[0:41];
      chk_cap("ur", ex);
    end

    // back-to-back: second frame waits through the IPG
    run_frame(1'b0, p2, -1, 1'b1, -1);
    chk("b2b.rdy_ipg", rdy_late, 0);
    chk_cap("b2b1", exp_frame(p2, 0, crc_ref(p2)));
    f1 = fall_g;
    run_frame(1'b0, ab, -1, 1'b0, -1);
    chk("b2b.gap", rise_g - f1, 49);
    chk_cap("b2b2", exp_frame(ab, 0, crc_ref(ab)));

    // reset in the middle of payload, then a clean frame
    run_frame(1'b0, p20, -1, 1'b0, 40);
    chk("mrst.txen", rst_e, 0);
    chk("mrst.busy", rst_b, 0);
    run_frame(1'b0, s9, -1, 1'b0, -1);
    chk("mrst.rise", rise_c, 2);
    chk_cap("mrst", exp_frame(s9, 0, 32'hCBF43926));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncomp, nfail);
    $finish;
  end

endmodule
